// File: rtl/pkt_seq_checker_pkg.sv
// Shared FSM state encoding for the packet checker family of blocks.
// Holds the 4-bit state width and the five named state constants.
package pkt_seq_checker_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    RESET_STATE = 4'd0,
    FIRST_PKT   = 4'd1,
    REG_PKT     = 4'd2,
    F_ERROR     = 4'd3,
    SEQ_ERROR   = 4'd4
  } state_t;

endpackage

// File: rtl/pkt_seq_checker_word_rev_reg.sv
// word_rev_reg: one-cycle register stage that reverses word order across the bus.
// Output word k takes input word WORD_NUM-1-k; synchronous active-high reset.
module word_rev_reg #(
  parameter int unsigned WORD_SIZE = 4,
  parameter int unsigned WORD_NUM  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  input  logic [WORD_SIZE*WORD_NUM-1:0] bus_data_in,
  output logic                          valid_out,
  output logic [WORD_SIZE*WORD_NUM-1:0] bus_data_out
);

  always_ff @(posedge clk) begin
    if (reset) valid_out <= 1'b0;
    else       valid_out <= valid_in;
  end

  for (genvar k = 0; k < WORD_NUM; k++) begin : g_word
    always_ff @(posedge clk) begin
      if (reset) bus_data_out[k*WORD_SIZE +: WORD_SIZE] <= '0;
      else       bus_data_out[k*WORD_SIZE +: WORD_SIZE] <=
                   bus_data_in[(WORD_NUM-1-k)*WORD_SIZE +: WORD_SIZE];
    end
  end

endmodule

// File: rtl/pkt_seq_checker.sv
// Packet framing/sequence checker with word-reversed, one-cycle-latency forwarding.
// Optional saturating error counter built only when ERR_COUNTER_EN is defined.
module pkt_seq_checker
  import pkt_seq_checker_pkg::*;
#(
  parameter int unsigned           BUS_SIZE  = 16,
  parameter int unsigned           WORD_SIZE = 4,
  parameter logic [WORD_SIZE-1:0]  HDR_VAL   = WORD_SIZE'('hF),
  parameter logic [WORD_SIZE-1:0]  SEQ_START = WORD_SIZE'(1),
  parameter int unsigned           ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic [BUS_SIZE-1:0]  bus_data_in,
  output logic                 valid_out,
  output logic [BUS_SIZE-1:0]  bus_data_out,
  output logic [STATE_W-1:0]   state,
  output logic                 error,
  output logic [WORD_SIZE-1:0] seq_expected,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned WORD_NUM = BUS_SIZE / WORD_SIZE;

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] seq_q, seq_d;
  logic [WORD_SIZE-1:0] hdr_in, seq_in;

  assign hdr_in = bus_data_in[BUS_SIZE-1 -: WORD_SIZE];
  assign seq_in = bus_data_in[WORD_SIZE-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_STATE;
      seq_q   <= SEQ_START;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
    end
  end

  // Framing is checked before sequence so a bad header always reports F_ERROR.
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    case (state_q)
      RESET_STATE: state_d = FIRST_PKT;
      FIRST_PKT, REG_PKT: begin
        if (valid_in) begin
          if (hdr_in != HDR_VAL) begin
            state_d = F_ERROR;
          end else if (seq_in != seq_q) begin
            state_d = SEQ_ERROR;
          end else begin
            state_d = REG_PKT;
            seq_d   = seq_q + 1'b1;
          end
        end
      end
      F_ERROR, SEQ_ERROR: begin
        state_d = FIRST_PKT;
        seq_d   = SEQ_START;
      end
      default: state_d = RESET_STATE;
    endcase
  end

  assign state        = state_q;
  assign seq_expected = seq_q;
  assign error        = (state_q == F_ERROR) || (state_q == SEQ_ERROR);

`ifdef ERR_COUNTER_EN
  logic                 enter_err;
  logic [ERR_CNT_W-1:0] err_q;

  assign enter_err = ((state_d == F_ERROR) || (state_d == SEQ_ERROR)) && !error;

  always_ff @(posedge clk) begin
    if (reset)                        err_q <= '0;
    else if (enter_err && err_q != '1) err_q <= err_q + 1'b1;
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

  word_rev_reg #(
    .WORD_SIZE (WORD_SIZE),
    .WORD_NUM  (WORD_NUM)
  ) u_word_rev_reg (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .bus_data_in  (bus_data_in),
    .valid_out    (valid_out),
    .bus_data_out (bus_data_out)
  );

endmodule
